// File: rtl/bus_pkg.sv
// Shared definitions for the core memory bus: chip-select codes, address
// regions, transfer sizes and the arbiter state encoding.
package bus_pkg;

  localparam logic [2:0] CS_NONE = 3'b000;
  localparam logic [2:0] CS_ROM  = 3'b001;
  localparam logic [2:0] CS_RAM  = 3'b010;
  localparam logic [2:0] CS_UART = 3'b100;

  // Region is selected by addr[31:28].
  localparam logic [3:0] REGION_ROM  = 4'h0;
  localparam logic [3:0] REGION_RAM  = 4'h1;
  localparam logic [3:0] REGION_UART = 4'h2;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Maps the top address nibble to a one-hot chip select; unmapped regions give
// CS_NONE with mapped_o low. Shared by the arbiter and the LSU.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [3:0] region_i,
  output logic [2:0] cs_o,
  output logic       mapped_o
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cs_o     = CS_NONE;
    mapped_o = 1'b0;
    case (region_i)
      REGION_ROM:  begin cs_o = CS_ROM;  mapped_o = 1'b1; end
      REGION_RAM:  begin cs_o = CS_RAM;  mapped_o = 1'b1; end
      REGION_UART: begin cs_o = CS_UART; mapped_o = 1'b1; end
      default:     begin cs_o = CS_NONE; mapped_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory bus: latches the
// winner's request, strobes the decoded slave and returns done/err/rdata.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_hb_i,
  output logic        m0_gnt_o,
  output logic        m0_done_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_hb_i,
  output logic        m1_gnt_o,
  output logic        m1_done_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_data_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_hb_o,
  output logic [2:0]  bus_cs_o,
  output logic        bus_stb_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state, state_nxt;

  logic             owner;
  logic             last_owner;
  logic [1:0]       gnt_q;
  logic [2:0]       cs_q;
  logic [CNT_W-1:0] timeout_cnt;

  logic        any_req;
  logic        pick;
  logic [31:0] sel_addr;
  logic [2:0]  sel_cs;
  logic        sel_mapped;
  logic        timeout_hit;
  logic        done;
  logic        err;

  assign any_req  = m0_req_i | m1_req_i;
  // On a tie the master not served last wins; otherwise the lone requester.
  assign pick     = (m0_req_i && m1_req_i) ? ~last_owner : m1_req_i;
  assign sel_addr = pick ? m1_addr_i : m0_addr_i;

  bus_addr_decode u_decode (
    .region_i (sel_addr[31:28]),
    .cs_o     (sel_cs),
    .mapped_o (sel_mapped)
  );

  assign timeout_hit = (timeout_cnt == CNT_LAST);
  // Ack wins over a timeout landing in the same cycle.
  assign done = (state == ERR) || ((state == BUSY) && (bus_ack_i || timeout_hit));
  assign err  = (state == ERR) || ((state == BUSY) && !bus_ack_i && timeout_hit);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = sel_mapped ? BUSY : ERR;
      BUSY:    if (bus_ack_i || timeout_hit) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner       <= 1'b0;
      last_owner  <= 1'b0;
      gnt_q       <= 2'b00;
      cs_q        <= CS_NONE;
      timeout_cnt <= '0;
      bus_addr_o  <= '0;
      bus_data_o  <= '0;
      bus_we_o    <= 1'b0;
      bus_hb_o    <= HB_BYTE;
    end else begin
      gnt_q <= 2'b00;
      if (state == IDLE && any_req) begin
        owner       <= pick;
        gnt_q       <= pick ? 2'b10 : 2'b01;
        cs_q        <= sel_cs;
        timeout_cnt <= '0;
        bus_addr_o  <= sel_addr;
        bus_data_o  <= pick ? m1_wdata_i : m0_wdata_i;
        bus_we_o    <= pick ? m1_we_i    : m0_we_i;
        bus_hb_o    <= pick ? m1_hb_i    : m0_hb_i;
      end else if (state == BUSY && !bus_ack_i) begin
        timeout_cnt <= timeout_cnt + CNT_W'(1);
      end
      // Any completion, including a timeout, counts as having been served.
      if (done) last_owner <= owner;
    end
  end

  always_comb begin
    bus_stb_o  = (state == BUSY);
    bus_cs_o   = (state == BUSY) ? cs_q : CS_NONE;
    m0_gnt_o   = gnt_q[0];
    m1_gnt_o   = gnt_q[1];
    m0_done_o  = done && !owner;
    m1_done_o  = done && owner;
    m0_err_o   = err && !owner;
    m1_err_o   = err && owner;
    m0_rdata_o = '0;
    m1_rdata_o = '0;
    if (state == BUSY && bus_ack_i) begin
      if (owner) m1_rdata_o = bus_rdata_i;
      else       m0_rdata_o = bus_rdata_i;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fixed stimulus steps with hand-computed
// expectations, one comparison per immediate assertion.
module tb_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_req_i, m0_we_i, m0_gnt_o, m0_done_o, m0_err_o;
  logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
  logic [1:0]  m0_hb_i;
  logic        m1_req_i, m1_we_i, m1_gnt_o, m1_done_o, m1_err_o;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic [1:0]  m1_hb_i;
  logic [31:0] bus_addr_o, bus_data_o, bus_rdata_i;
  logic        bus_we_o, bus_stb_o, bus_ack_i;
  logic [1:0]  bus_hb_o;
  logic [2:0]  bus_cs_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_we_i(m0_we_i), .m0_hb_i(m0_hb_i), .m0_gnt_o(m0_gnt_o),
    .m0_done_o(m0_done_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_we_i(m1_we_i), .m1_hb_i(m1_hb_i), .m1_gnt_o(m1_gnt_o),
    .m1_done_o(m1_done_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o),
    .bus_hb_o(bus_hb_o), .bus_cs_o(bus_cs_o), .bus_stb_o(bus_stb_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven
  // there and outputs checked one unit later, both clear of the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stb"},  32'(bus_stb_o), 32'd0);
    check({tag, "_gnt"},  32'({m1_gnt_o, m0_gnt_o}), 32'd0);
    check({tag, "_done"}, 32'({m1_done_o, m0_done_o}), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    m0_req_i = 0; m0_addr_i = 0; m0_wdata_i = 0; m0_we_i = 0; m0_hb_i = 2'b10;
    m1_req_i = 0; m1_addr_i = 0; m1_wdata_i = 0; m1_we_i = 0; m1_hb_i = 2'b10;
    bus_ack_i = 0; bus_rdata_i = 0;
    step();
    step();
    #1;
    check_quiet("reset");
    check("reset_addr", bus_addr_o, 32'h0);
    check("reset_cs", 32'(bus_cs_o), 32'h0);
    check("reset_err", 32'({m1_err_o, m0_err_o}), 32'h0);
    rst_i = 1'b0;

    // m0 ROM read with same-cycle ack.
    step();
    m0_req_i = 1; m0_addr_i = 32'h0000_0010;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'hDEAD_BEEF;
    #1;
    check("rd_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'b01);
    check("rd_done", 32'({m1_done_o, m0_done_o}), 32'b01);
    check("rd_err", 32'(m0_err_o), 32'd0);
    check("rd_rdata", m0_rdata_o, 32'hDEAD_BEEF);
    check("rd_cs", 32'(bus_cs_o), 32'b001);
    check("rd_addr", bus_addr_o, 32'h0000_0010);
    m0_req_i = 0;
    step();
    bus_ack_i = 0;
    #1;
    check_quiet("rd_idle");

    // Tie from reset: m1, m0, m1, m0 with an idle cycle between grants.
    rst_i = 1;
    step();
    rst_i = 0;
    m0_req_i = 1; m0_addr_i = 32'h1000_0000;
    m1_req_i = 1; m1_addr_i = 32'h1000_0100;
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_0001;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_m;
      exp_m = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
      #1;
      check("rr_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'(exp_m));
      check("rr_done", 32'({m1_done_o, m0_done_o}), 32'(exp_m));
      check("rr_addr", bus_addr_o, (i % 2 == 0) ? 32'h1000_0100 : 32'h1000_0000);
      if (i == 3) begin m0_req_i = 0; m1_req_i = 0; end
      step();
      #1;
      check_quiet("rr_idle");
    end
    bus_ack_i = 0;

    // m1 RAM write, ack three cycles late; payload changes ignored.
    m1_req_i = 1; m1_addr_i = 32'h1000_0004; m1_wdata_i = 32'h1234_5678;
    m1_we_i = 1; m1_hb_i = 2'b10;
    step();
    #1;
    check("wr_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'b10);
    check("wr_we", 32'(bus_we_o), 32'd1);
    check("wr_hb", 32'(bus_hb_o), 32'b10);
    check("wr_cs", 32'(bus_cs_o), 32'b010);
    m1_wdata_i = 32'hFFFF_FFFF; m1_addr_i = 32'h2000_0000; m1_we_i = 0;
    for (int k = 2; k <= 3; k++) begin
      step();
      #1;
      check("wr_wait_done", 32'(m1_done_o), 32'd0);
      check("wr_wait_data", bus_data_o, 32'h1234_5678);
    end
    step();
    bus_ack_i = 1;
    #1;
    check("wr_done", 32'({m1_done_o, m0_done_o}), 32'b10);
    check("wr_err", 32'(m1_err_o), 32'd0);
    check("wr_data", bus_data_o, 32'h1234_5678);
    check("wr_addr", bus_addr_o, 32'h1000_0004);
    m1_req_i = 0;
    step();
    bus_ack_i = 0;

    // m1 unmapped read: ERR for one cycle, stray ack ignored.
    m1_req_i = 1; m1_addr_i = 32'h3000_0000; m1_we_i = 0;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'hAAAA_AAAA;
    #1;
    check("um_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'b10);
    check("um_done", 32'({m1_done_o, m0_done_o}), 32'b10);
    check("um_err", 32'(m1_err_o), 32'd1);
    check("um_rdata", m1_rdata_o, 32'h0);
    check("um_stb", 32'(bus_stb_o), 32'd0);
    check("um_cs", 32'(bus_cs_o), 32'b000);
    m1_req_i = 0;
    step();
    bus_ack_i = 0;
    #1;
    check_quiet("um_idle");

    // m0 UART read, no ack: done+err on the 16th strobe cycle.
    m0_req_i = 1; m0_addr_i = 32'h2000_0000;
    for (int k = 1; k <= 16; k++) begin
      step();
      #1;
      check("to_stb", 32'(bus_stb_o), 32'd1);
      check("to_done", 32'(m0_done_o), (k == 16) ? 32'd1 : 32'd0);
    end
    check("to_err", 32'(m0_err_o), 32'd1);
    check("to_rdata", m0_rdata_o, 32'h0);
    check("to_cs", 32'(bus_cs_o), 32'b100);
    m0_req_i = 0;
    step();
    #1;
    check_quiet("to_idle");

    // Ack coincident with the final count: ack wins.
    m0_req_i = 1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 16) begin bus_ack_i = 1; bus_rdata_i = 32'h0000_0055; end
      #1;
      check("ta_done", 32'(m0_done_o), (k == 16) ? 32'd1 : 32'd0);
    end
    check("ta_err", 32'(m0_err_o), 32'd0);
    check("ta_rdata", m0_rdata_o, 32'h0000_0055);
    m0_req_i = 0;
    step();
    bus_ack_i = 0;

    // Reset during BUSY aborts silently; re-request completes.
    m0_req_i = 1; m0_addr_i = 32'h1000_0008; m0_wdata_i = 32'h7777_7777; m0_we_i = 1;
    step();
    #1;
    check("rb_stb", 32'(bus_stb_o), 32'd1);
    rst_i = 1;
    step();
    #1;
    check_quiet("rb_reset");
    check("rb_addr", bus_addr_o, 32'h0);
    check("rb_data", bus_data_o, 32'h0);
    check("rb_we", 32'(bus_we_o), 32'd0);
    check("rb_cs", 32'(bus_cs_o), 32'd0);
    rst_i = 0;
    step();
    bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D;
    #1;
    check("rb_gnt", 32'({m1_gnt_o, m0_gnt_o}), 32'b01);
    check("rb_done", 32'({m1_done_o, m0_done_o}), 32'b01);
    check("rb_rdata", m0_rdata_o, 32'h0BAD_F00D);
    check("rb_addr2", bus_addr_o, 32'h1000_0008);
    m0_req_i = 0;
    step();
    bus_ack_i = 0;
    #1;
    check_quiet("rb_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
